// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write path.
// Imported by the write arbiter, its round-robin sub-block and its bus interface.
package rf_ctrl_pkg;

    localparam int RF_WIDTH    = 32;
    localparam int RF_NUM_REGS = 32;
    localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);
    localparam int NUM_WB_REQ  = 2;

    typedef logic [4:0]          rf_addr_t;
    typedef logic [RF_WIDTH-1:0] rf_data_t;

    // Writeback requester identities; the value doubles as the request bit index.
    typedef enum logic {
        REQ_EXE = 1'b0,
        REQ_LD  = 1'b1
    } req_id_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of writeback requests, register-file write port and issue-stage hazard signals.
// The master side is the pipeline; the slave side is the write arbiter.
interface rf_write_arbiter_if #(
    parameter int WIDTH  = rf_ctrl_pkg::RF_WIDTH,
    parameter int ADDR_W = rf_ctrl_pkg::RF_ADDR_W
);

    logic [rf_ctrl_pkg::NUM_WB_REQ-1:0] req_valid;
    logic [rf_ctrl_pkg::NUM_WB_REQ-1:0] req_ready;
    logic [ADDR_W-1:0]                  req_addr0;
    logic [ADDR_W-1:0]                  req_addr1;
    logic [WIDTH-1:0]                   req_data0;
    logic [WIDTH-1:0]                   req_data1;

    logic                               rf_en;
    logic [ADDR_W-1:0]                  write_addr;
    logic [WIDTH-1:0]                   write_data;

    logic                               issue_valid;
    logic [ADDR_W-1:0]                  issue_rd;
    logic [ADDR_W-1:0]                  rs_a;
    logic [ADDR_W-1:0]                  rs_b;
    logic                               stall;

    modport master (
        output req_valid, req_addr0, req_addr1, req_data0, req_data1,
        output issue_valid, issue_rd, rs_a, rs_b,
        input  req_ready, rf_en, write_addr, write_data, stall
    );

    modport slave (
        input  req_valid, req_addr0, req_addr1, req_data0, req_data1,
        input  issue_valid, issue_rd, rs_a, rs_b,
        output req_ready, rf_en, write_addr, write_data, stall
    );

endinterface

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Two-way round-robin grant for the register-file write port.
// Grant is combinational from the valid bits; only the tie-break pointer is stored.
module rf_rr_arbiter
    import rf_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_WB_REQ-1:0] req_valid,
    output logic [NUM_WB_REQ-1:0] grant
);

    // rr_ptr names the requester that wins the next tie, so reset favours req0.
    req_id_t rr_ptr;

    always_comb begin
        grant = '0;
        if (rst_n) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (rr_ptr == REQ_EXE) ? 2'b01 : 2'b10;
                default: grant = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= REQ_EXE;
        end else if (grant[REQ_EXE]) begin
            rr_ptr <= REQ_LD;
        end else if (grant[REQ_LD]) begin
            rr_ptr <= REQ_EXE;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Owns the register-file write port: arbitrates two writeback sources, registers the
// write, and tracks in-flight destinations to raise RAW/WAW stalls at issue.
module rf_write_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int NUM_REGS = RF_NUM_REGS
) (
    input  logic             clk,
    input  logic             rst_n,
    rf_write_arbiter_if.slave bus
);

    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [NUM_WB_REQ-1:0] grant;
    logic                  transfer;
    logic                  write_hit;
    logic [ADDR_W-1:0]     sel_addr;
    logic [WIDTH-1:0]      sel_data;

    logic                  rf_en_q;
    logic [ADDR_W-1:0]     write_addr_q;
    logic [WIDTH-1:0]      write_data_q;

    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_next;
    logic                  stall_c;
    logic                  busy_set;

    rf_rr_arbiter u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (bus.req_valid),
        .grant     (grant)
    );

    assign bus.req_ready = grant;
    assign transfer      = |grant;

    always_comb begin
        sel_addr = bus.req_addr0;
        sel_data = bus.req_data0;
        if (grant[REQ_LD]) begin
            sel_addr = bus.req_addr1;
            sel_data = bus.req_data1;
        end
    end

    // Writes to x0 are still handshaken so the requester can retire, but never reach the RF.
    assign write_hit = transfer && (sel_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_en_q      <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            rf_en_q <= write_hit;
            if (write_hit) begin
                write_addr_q <= sel_addr;
                write_data_q <= sel_data;
            end
        end
    end

    assign bus.rf_en      = rf_en_q;
    assign bus.write_addr = write_addr_q;
    assign bus.write_data = write_data_q;

    // No bypass: a destination stays busy until the edge on which the RF commits it.
    assign stall_c  = bus.issue_valid &&
                      (busy_q[bus.rs_a] || busy_q[bus.rs_b] || busy_q[bus.issue_rd]);
    assign bus.stall = stall_c;
    assign busy_set = bus.issue_valid && !stall_c && (bus.issue_rd != '0);

    // Clear is applied before set so a new producer wins over a retiring one.
    always_comb begin
        busy_next = busy_q;
        if (rf_en_q) begin
            busy_next[write_addr_q] = 1'b0;
        end
        if (busy_set) begin
            busy_next[bus.issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomised and directed bench for rf_write_arbiter against a transaction-level model
// holding a gold register file, a busy set and the single pending write.
module tb_rf_write_arbiter;
    import rf_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rf_write_arbiter_if #(.WIDTH(32), .ADDR_W(5)) bus();

    rf_write_arbiter #(.WIDTH(32), .NUM_REGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural register file fed only by the DUT write port.
    logic [31:0] tb_rf [32];
    always @(posedge clk) begin
        if (bus.rf_en) tb_rf[bus.write_addr] <= bus.write_data;
    end

    int checks = 0;
    int errors = 0;

    logic [31:0] gold [32];
    bit          m_busy [32];
    bit          m_pend;
    logic [4:0]  m_pend_addr;
    logic [31:0] m_pend_data;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    int          m_last_won;

    logic [1:0]  obs_ready;
    logic        obs_stall;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
        m_pend     = 1'b0;
        m_waddr    = '0;
        m_wdata    = '0;
        m_last_won = 1;
    endtask

    // One clock of stimulus: combinational outputs checked mid-cycle, registered ones after the edge.
    task automatic applyStimulus(input logic [1:0] v,
                                 input logic [4:0] a0, input logic [31:0] d0,
                                 input logic [4:0] a1, input logic [31:0] d1,
                                 input logic iv, input logic [4:0] rd,
                                 input logic [4:0] ra, input logic [4:0] rb,
                                 output int granted);
        int          g;
        logic        exp_stall;
        bit          commit;
        logic [4:0]  commit_addr;
        logic [4:0]  a;
        logic [31:0] d;
        @(negedge clk);
        bus.req_valid   = v;
        bus.req_addr0   = a0;
        bus.req_data0   = d0;
        bus.req_addr1   = a1;
        bus.req_data1   = d1;
        bus.issue_valid = iv;
        bus.issue_rd    = rd;
        bus.rs_a        = ra;
        bus.rs_b        = rb;
        #1;
        if (v == 2'b11)  g = 1 - m_last_won;
        else if (v[0])   g = 0;
        else if (v[1])   g = 1;
        else             g = -1;
        exp_stall = iv && (m_busy[ra] || m_busy[rb] || m_busy[rd]);
        obs_ready = bus.req_ready;
        obs_stall = bus.stall;
        checkOutput("req_ready", {30'b0, bus.req_ready}, (g < 0) ? 32'd0 : ((g == 0) ? 32'd1 : 32'd2));
        checkOutput("stall", {31'b0, bus.stall}, {31'b0, exp_stall});
        @(posedge clk);
        commit      = m_pend;
        commit_addr = m_pend_addr;
        if (m_pend) begin
            gold[m_pend_addr]   = m_pend_data;
            m_busy[m_pend_addr] = 1'b0;
        end
        if (iv && !exp_stall && rd != 0) m_busy[rd] = 1'b1;
        m_pend = 1'b0;
        if (g >= 0) begin
            m_last_won = g;
            a = (g == 1) ? a1 : a0;
            d = (g == 1) ? d1 : d0;
            if (a != 0) begin
                m_pend      = 1'b1;
                m_pend_addr = a;
                m_pend_data = d;
                m_waddr     = a;
                m_wdata     = d;
            end
        end
        #1;
        checkOutput("rf_en", {31'b0, bus.rf_en}, {31'b0, m_pend});
        checkOutput("write_addr", {27'b0, bus.write_addr}, {27'b0, m_waddr});
        checkOutput("write_data", bus.write_data, m_wdata);
        if (commit) checkOutput("rf_commit", tb_rf[commit_addr], gold[commit_addr]);
        granted = g;
    endtask

    // Asynchronous reset asserted between edges; checked immediately and across one edge.
    task automatic pulseReset();
        #1;
        rst_n           = 1'b0;
        bus.req_valid   = 2'b11;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd9;
        bus.rs_a        = 5'd3;
        bus.rs_b        = 5'd7;
        #1;
        checkOutput("rst_rf_en", {31'b0, bus.rf_en}, 32'd0);
        checkOutput("rst_write_addr", {27'b0, bus.write_addr}, 32'd0);
        checkOutput("rst_write_data", bus.write_data, 32'd0);
        checkOutput("rst_ready", {30'b0, bus.req_ready}, 32'd0);
        checkOutput("rst_stall", {31'b0, bus.stall}, 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("rst_hold_rf_en", {31'b0, bus.rf_en}, 32'd0);
        @(negedge clk);
        bus.req_valid   = 2'b00;
        bus.issue_valid = 1'b0;
        rst_n           = 1'b1;
    endtask

    initial begin : main
        int          g;
        bit          h0, h1;
        logic        v0, v1, iv;
        logic [4:0]  a0, a1, rd, ra, rb;
        logic [31:0] d0, d1;

        for (int r = 0; r < 32; r++) begin
            tb_rf[r] = '0;
            gold[r]  = '0;
        end
        bus.req_valid = '0;  bus.req_addr0 = '0;  bus.req_addr1 = '0;
        bus.req_data0 = '0;  bus.req_data1 = '0;
        bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.rs_a = '0; bus.rs_b = '0;
        modelReset();

        @(posedge clk);
        pulseReset();

        // Contention from reset: grants alternate starting with req0.
        applyStimulus(2'b11, 5'd3, 32'hA000_0000, 5'd4, 32'hB000_0000, 1'b0, 5'd0, 5'd0, 5'd0, g);
        checkOutput("t2_grant0", {30'b0, obs_ready}, 32'd1);
        applyStimulus(2'b11, 5'd3, 32'hA000_0001, 5'd4, 32'hB000_0000, 1'b0, 5'd0, 5'd0, 5'd0, g);
        checkOutput("t2_grant1", {30'b0, obs_ready}, 32'd2);
        applyStimulus(2'b11, 5'd3, 32'hA000_0001, 5'd4, 32'hB000_0001, 1'b0, 5'd0, 5'd0, 5'd0, g);
        checkOutput("t2_grant2", {30'b0, obs_ready}, 32'd1);
        applyStimulus(2'b11, 5'd3, 32'hA000_0002, 5'd4, 32'hB000_0001, 1'b0, 5'd0, 5'd0, 5'd0, g);
        checkOutput("t2_grant3", {30'b0, obs_ready}, 32'd2);
        checkOutput("t2_write_data", bus.write_data, 32'hB000_0001);

        // Single requester write.
        applyStimulus(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, g);
        checkOutput("t1_ready", {30'b0, obs_ready}, 32'd1);
        checkOutput("t1_rf_en", {31'b0, bus.rf_en}, 32'd1);
        applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, g);
        checkOutput("t1_rf5", tb_rf[5], 32'hDEAD_BEEF);

        // Write to x0 is accepted but dropped.
        applyStimulus(2'b10, 5'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0, 5'd0, g);
        checkOutput("t3_ready", {30'b0, obs_ready}, 32'd2);
        checkOutput("t3_rf_en", {31'b0, bus.rf_en}, 32'd0);
        applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, g);
        checkOutput("t3_rf0", tb_rf[0], 32'd0);

        // RAW on reg 7 stalls until the edge that commits it.
        applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd0, g);
        checkOutput("t4_issue", {31'b0, obs_stall}, 32'd0);
        applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd7, 5'd0, g);
        checkOutput("t4_stall_a", {31'b0, obs_stall}, 32'd1);
        applyStimulus(2'b01, 5'd7, 32'h0000_0777, 5'd0, 32'd0, 1'b1, 5'd0, 5'd7, 5'd0, g);
        checkOutput("t4_stall_b", {31'b0, obs_stall}, 32'd1);
        applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd7, 5'd0, g);
        checkOutput("t4_stall_c", {31'b0, obs_stall}, 32'd1);
        applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd7, 5'd0, g);
        checkOutput("t4_released", {31'b0, obs_stall}, 32'd0);

        // Set and clear of reg 9 on the same edge: set wins.
        applyStimulus(2'b01, 5'd9, 32'h9999_0000, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, g);
        applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd0, g);
        checkOutput("t5_set", {31'b0, obs_stall}, 32'd0);
        applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd0, g);
        checkOutput("t5_waw", {31'b0, obs_stall}, 32'd1);

        // Reset with busy regs and a pending write to reg 5.
        applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 5'd0, g);
        applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd0, g);
        applyStimulus(2'b01, 5'd5, 32'h1234_5678, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, g);
        pulseReset();
        applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd3, 5'd7, g);
        checkOutput("t6_busy_clr", {31'b0, obs_stall}, 32'd0);
        checkOutput("t6_rf5", tb_rf[5], 32'hDEAD_BEEF);

        // Random traffic; a requester holds its request until it is granted.
        h0 = 1'b0; h1 = 1'b0;
        v0 = 1'b0; v1 = 1'b0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int i = 0; i < 600; i++) begin
            if (!h0) begin
                v0 = ($urandom_range(0, 99) < 60);
                a0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
                d0 = $urandom;
            end
            if (!h1) begin
                v1 = ($urandom_range(0, 99) < 60);
                a1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
                d1 = $urandom;
            end
            iv = ($urandom_range(0, 99) < 50);
            rd = 5'($urandom_range(0, 15));
            ra = 5'($urandom_range(0, 15));
            rb = 5'($urandom_range(0, 15));
            applyStimulus({v1, v0}, a0, d0, a1, d1, iv, rd, ra, rb, g);
            h0 = v0 && (g != 0);
            h1 = v1 && (g != 1);
        end
        applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, g);

        for (int r = 0; r < 32; r++) begin
            checkOutput($sformatf("rf_final_%0d", r), tb_rf[r], gold[r]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
